circ_history_buffer: RTL and testbench
======================================

// Module: circ_history_buffer
// PURPOSE
//  Parametrised circular history buffer; successor to the fixed 8x16 sample array.
//  Writes land at an auto-incrementing, wrapping pointer. Reads are addressed by lag
//  from the newest sample, with registered data, valid and miss flags.
//  Tracks fill level and a sticky wrap flag; sits between a sample source and debug/trace logic.
// PARAMETERS
//  DATA_W   8    width of one stored sample
//  DEPTH    16   number of entries; power of 2, >= 2
//  AW       $clog2(DEPTH)   localparam, pointer/lag width
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  clr         in   1         synchronous clear of pointer/fill/wrap state
//  wr_en       in   1         write wr_data this cycle
//  wr_data     in   DATA_W    sample to store
//  rd_en       in   1         read request
//  rd_lag      in   AW        0 = newest written sample, 1 = one before, ...
//  rd_data     out  DATA_W    registered read data
//  rd_valid    out  1         one-cycle pulse, cycle after rd_en
//  rd_miss     out  1         with rd_valid: requested lag not yet written
//  wr_ptr      out  AW        next write address
//  fill        out  AW+1      valid entries, saturates at DEPTH
//  wrapped     out  1         sticky: pointer has wrapped at least once
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=0, fill=0, wrapped=0, rd_data=0, rd_valid=0, rd_miss=0.
//    Storage array is not reset.
//  - Write: wr_en=1 -> mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1 mod DEPTH.
//    fill<=min(fill+1,DEPTH). wrapped<=1 when wr_ptr goes DEPTH-1 -> 0.
//  - Read, 1-cycle latency: rd_en in cycle N -> in N+1, rd_valid=1 and
//    rd_data=mem[(wr_ptr-1-rd_lag) mod DEPTH]. Address and fill use cycle-N values.
//  - Read-before-write: a write in the same cycle as rd_en is NOT visible to that read.
//  - Miss: rd_lag >= fill (cycle N) -> rd_miss=1, rd_data=0 in N+1; else rd_miss=0.
//  - rd_data holds its last value when rd_en=0. rd_valid and rd_miss are 0 when no read completes.
//  - clr=1: wr_ptr<=0, fill<=0, wrapped<=0. clr has priority over wr_en (write dropped).
//    A rd_en in the clr cycle still completes, using the pre-clear state.
//  - Back-to-back reads every cycle are supported, one result per cycle.
//  - Reset mid-operation aborts any pending read: rd_valid=0 immediately.
//  - Arithmetic: pointer math is modulo 2^AW (natural wrap); fill compare is AW+1 bits.
// CONFIGURATION
//  HIST_BUF_PARITY_EN defined:
//   - Each entry stores DATA_W+1 bits, with even parity computed at write.
//   - Extra ports: wr_par_inv (in,1) inverts the stored parity bit, for fault injection;
//     rd_par_err (out,1) is asserted with rd_valid when the stored parity mismatches.
//   - rd_par_err=0 on miss and in reset.
//  HIST_BUF_PARITY_EN undefined:
//   - Storage is DATA_W wide; wr_par_inv and rd_par_err are absent.
//   - All other behaviour is identical.
// TESTING
//  1. Reset, then write 0x11,0x22,0x33; rd_lag=0 -> 0x33, lag=2 -> 0x11, each rd_valid=1, rd_miss=0.
//  2. After 3 writes, rd_lag=3 -> rd_valid=1, rd_miss=1, rd_data=0; fill=3.
//  3. Write 20 samples 0..19 (DEPTH=16): fill=16, wrapped=1, wr_ptr=4;
//     lag=0 -> 19, lag=15 -> 4.
//  4. Same cycle wr_en(0xAA)+rd_en lag=0 after last write 0x55 -> rd_data=0x55;
//     next read lag=0 -> 0xAA.
//  5. clr with wr_en=1 -> wr_ptr=0, fill=0, wrapped=0, write dropped;
//     rd_en in the clr cycle returns pre-clear data. rst_n low mid-read -> rd_valid=0.
//  6. (PARITY_EN) write 0x0F with wr_par_inv=1, read lag=0 -> rd_data=0x0F, rd_par_err=1;
//     rewrite with wr_par_inv=0 -> rd_par_err=0.

Source files
------------

// File: rtl/circ_history_buffer.sv
// -----------------------------------------------------------------------------
// circ_history_buffer
//   Parametrised circular history buffer. Samples are written at an
//   auto-incrementing, wrapping pointer; reads are addressed by lag from the
//   newest sample and return registered data together with valid and miss flags.
//   Fill level (saturating at DEPTH) and a sticky wrap flag are tracked.
//
//   Optional feature macro: HIST_BUF_PARITY_EN
//     defined   -> each entry carries an even-parity bit, wr_par_inv / rd_par_err
//                  ports are present.
//     undefined -> plain DATA_W-wide storage, no parity ports.
// -----------------------------------------------------------------------------
module circ_history_buffer #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_lag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_miss,
    output logic [AW-1:0]     wr_ptr,
    output logic [AW:0]       fill,
    output logic              wrapped
`ifdef HIST_BUF_PARITY_EN
    ,
    input  logic              wr_par_inv,
    output logic              rd_par_err
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
`ifdef HIST_BUF_PARITY_EN
    localparam int MW = DATA_W + 1;       // stored word: {parity, data}
`else
    localparam int MW = DATA_W;           // stored word: data only
`endif

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   FILL_ZERO = (AW + 1)'(0);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

`ifdef HIST_BUF_PARITY_EN
    // Even parity bit: makes the XOR over {parity, data} equal to zero.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // True when a stored {parity, data} word no longer has even parity.
    function automatic logic parity_bad(input logic [MW-1:0] w);
        return ^w;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Storage and state registers
    // -------------------------------------------------------------------------
    logic [MW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_fill;
    logic              r_wrapped;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_miss;
`ifdef HIST_BUF_PARITY_EN
    logic              r_rd_par_err;
`endif

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW:0]       w_fill_nxt;
    logic              w_wrapped_nxt;
    logic              w_mem_we;
    logic [MW-1:0]     w_wr_word;
    logic [AW-1:0]     w_rd_addr;
    logic [MW-1:0]     w_rd_word;
    logic              w_rd_lag_miss;
    logic [DATA_W-1:0] w_rd_data_nxt;
    logic              w_rd_valid_nxt;
    logic              w_rd_miss_nxt;
`ifdef HIST_BUF_PARITY_EN
    logic              w_rd_par_err_nxt;
`endif

    // Build the word to be stored (optionally with an intentionally bad parity bit).
    always_comb begin
`ifdef HIST_BUF_PARITY_EN
        w_wr_word = {even_parity(wr_data) ^ wr_par_inv, wr_data};
`else
        w_wr_word = wr_data;
`endif
    end

    // Pointer, fill and wrap next-state; clear wins over a concurrent write.
    always_comb begin
        w_wr_ptr_nxt  = r_wr_ptr;
        w_fill_nxt    = r_fill;
        w_wrapped_nxt = r_wrapped;
        w_mem_we      = 1'b0;
        if (clr) begin
            w_wr_ptr_nxt  = PTR_ZERO;
            w_fill_nxt    = FILL_ZERO;
            w_wrapped_nxt = 1'b0;
        end else if (wr_en) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;   // natural modulo-DEPTH wrap
            if (r_fill != FILL_MAX) begin
                w_fill_nxt = r_fill + FILL_ONE;
            end else begin
                w_fill_nxt = r_fill;
            end
            if (r_wr_ptr == PTR_LAST) begin
                w_wrapped_nxt = 1'b1;
            end else begin
                w_wrapped_nxt = r_wrapped;
            end
        end else begin
            w_wr_ptr_nxt  = r_wr_ptr;
            w_fill_nxt    = r_fill;
            w_wrapped_nxt = r_wrapped;
        end
    end

    // Read address from lag; uses the pre-write pointer so a same-cycle write is not seen.
    always_comb begin
        w_rd_addr     = r_wr_ptr - PTR_ONE - rd_lag;
        w_rd_word     = r_mem[w_rd_addr];
        w_rd_lag_miss = ({1'b0, rd_lag} >= r_fill);
    end

    // Read result next-state: data holds when idle, flags are single-cycle pulses.
    always_comb begin
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_rd_miss_nxt  = 1'b0;
`ifdef HIST_BUF_PARITY_EN
        w_rd_par_err_nxt = 1'b0;
`endif
        if (rd_en) begin
            w_rd_valid_nxt = 1'b1;
            if (w_rd_lag_miss) begin
                w_rd_miss_nxt = 1'b1;
                w_rd_data_nxt = DATA_ZERO;
            end else begin
                w_rd_miss_nxt = 1'b0;
                w_rd_data_nxt = w_rd_word[DATA_W-1:0];
`ifdef HIST_BUF_PARITY_EN
                w_rd_par_err_nxt = parity_bad(w_rd_word);
`endif
            end
        end else begin
            w_rd_data_nxt  = r_rd_data;
            w_rd_valid_nxt = 1'b0;
            w_rd_miss_nxt  = 1'b0;
        end
    end

    // Sample storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    // Pointer / fill / wrap state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= PTR_ZERO;
            r_fill    <= FILL_ZERO;
            r_wrapped <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_fill    <= w_fill_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    // Registered read outputs; reset aborts any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= DATA_ZERO;
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
`ifdef HIST_BUF_PARITY_EN
            r_rd_par_err <= 1'b0;
`endif
        end else begin
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_miss  <= w_rd_miss_nxt;
`ifdef HIST_BUF_PARITY_EN
            r_rd_par_err <= w_rd_par_err_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_miss  = r_rd_miss;
    assign wr_ptr   = r_wr_ptr;
    assign fill     = r_fill;
    assign wrapped  = r_wrapped;
`ifdef HIST_BUF_PARITY_EN
    assign rd_par_err = r_rd_par_err;
`endif

endmodule

// File: tb/tb_circ_history_buffer.sv
// -----------------------------------------------------------------------------
// tb_circ_history_buffer
//   Directed stimulus with hand-computed expected read results pushed into a
//   scoreboard queue; a separate monitor pops and compares on every rd_valid.
//   Parity cases are compiled in when HIST_BUF_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_circ_history_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [AW-1:0]     rd_lag;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_miss;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       fill;
    logic              wrapped;
    logic              wr_par_inv;
    logic              rd_par_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              miss;
        logic              perr;
    } exp_t;

    exp_t exp_q[$];

    circ_history_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_lag     (rd_lag),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_miss    (rd_miss),
        .wr_ptr     (wr_ptr),
        .fill       (fill),
        .wrapped    (wrapped)
`ifdef HIST_BUF_PARITY_EN
        ,
        .wr_par_inv (wr_par_inv),
        .rd_par_err (rd_par_err)
`endif
    );

`ifndef HIST_BUF_PARITY_EN
    assign rd_par_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed read against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no read");
            end else begin
                e = exp_q.pop_front();
                check("rd_data", {24'h0, rd_data}, {24'h0, e.data});
                check("rd_miss", {31'h0, rd_miss}, {31'h0, e.miss});
`ifdef HIST_BUF_PARITY_EN
                check("rd_par_err", {31'h0, rd_par_err}, {31'h0, e.perr});
`endif
            end
        end else begin
            check("rd_miss_idle", {31'h0, rd_miss}, 32'h0);
        end
    end

    // One stimulus cycle; a read pushes its expected result.
    task automatic step(input logic we, input logic [7:0] wd, input logic re,
                        input logic [3:0] lag, input logic cl, input logic inv,
                        input logic [7:0] ed, input logic em, input logic ep);
        exp_t e;
        @(negedge clk);
        wr_en      = we;
        wr_data    = wd;
        rd_en      = re;
        rd_lag     = lag;
        clr        = cl;
        wr_par_inv = inv;
        if (re) begin
            e.data = ed;
            e.miss = em;
            e.perr = ep;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] lag, input logic [7:0] ed, input logic em);
        step(1'b0, 8'h00, 1'b1, lag, 1'b0, 1'b0, ed, em, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string tag, input logic [3:0] ep,
                               input logic [4:0] ef, input logic ew);
        check({tag, "_wr_ptr"},  {28'h0, wr_ptr},  {28'h0, ep});
        check({tag, "_fill"},    {27'h0, fill},    {27'h0, ef});
        check({tag, "_wrapped"}, {31'h0, wrapped}, {31'h0, ew});
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        clr        = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        rd_en      = 1'b0;
        rd_lag     = 4'h0;
        wr_par_inv = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_state("reset", 4'd0, 5'd0, 1'b0);
        check("reset_rd_data",  {24'h0, rd_data}, 32'h0);
        check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("reset_rd_miss",  {31'h0, rd_miss}, 32'h0);
        rst_n = 1'b1;

        // Three writes, back-to-back reads by lag
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        rd(4'd0, 8'h33, 1'b0);
        rd(4'd2, 8'h11, 1'b0);
        rd(4'd1, 8'h22, 1'b0);
        idle();
        check_state("after3", 4'd3, 5'd3, 1'b0);
        idle();
        check("hold_rd_data",  {24'h0, rd_data}, 32'h22);
        check("hold_rd_valid", {31'h0, rd_valid}, 32'h0);

        // Misses at and beyond the fill level
        rd(4'd3, 8'h00, 1'b1);
        rd(4'd15, 8'h00, 1'b1);
        idle();

        // Clear with write and read in the same cycle: read sees pre-clear state
        step(1'b1, 8'hEE, 1'b1, 4'd0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        idle();
        check_state("clr1", 4'd0, 5'd0, 1'b0);
        rd(4'd0, 8'h00, 1'b1);

        // Fill to wrap: 0..14 then 15 crosses DEPTH-1 -> 0
        for (int i = 0; i < 15; i++) wr(8'(i));
        idle();
        check_state("w15", 4'd15, 5'd15, 1'b0);
        wr(8'd15);
        idle();
        check_state("w16", 4'd0, 5'd16, 1'b1);
        for (int i = 16; i < 20; i++) wr(8'(i));
        idle();
        check_state("w20", 4'd4, 5'd16, 1'b1);
        rd(4'd0, 8'd19, 1'b0);
        rd(4'd15, 8'd4, 1'b0);
        rd(4'd4, 8'd15, 1'b0);

        // Read-before-write in the same cycle
        wr(8'h55);
        step(1'b1, 8'hAA, 1'b1, 4'd0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        rd(4'd0, 8'hAA, 1'b0);
        rd(4'd1, 8'h55, 1'b0);
        idle();
        check_state("rbw", 4'd6, 5'd16, 1'b1);

        // Clear after wrap: write dropped, read returns pre-clear mem[3]
        step(1'b1, 8'h77, 1'b1, 4'd2, 1'b1, 1'b0, 8'd19, 1'b0, 1'b0);
        idle();
        check_state("clr2", 4'd0, 5'd0, 1'b0);
        rd(4'd0, 8'h00, 1'b1);
        wr(8'h99);
        rd(4'd0, 8'h99, 1'b0);
        rd(4'd1, 8'h00, 1'b1);
        idle();
        check_state("post_clr", 4'd1, 5'd1, 1'b0);

        // Reset asserted while a read result is on the outputs
        @(negedge clk);
        rd_en  = 1'b1;
        rd_lag = 4'd0;
        @(posedge clk);
        #1;
        check("midread_valid_before", {31'h0, rd_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midread_valid_after", {31'h0, rd_valid}, 32'h0);
        check("midread_rd_data", {24'h0, rd_data}, 32'h0);
        check_state("midread", 4'd0, 5'd0, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef HIST_BUF_PARITY_EN
        // Parity fault injection and recovery
        step(1'b1, 8'h0F, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1);
        step(1'b1, 8'h0F, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

        idle();
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
